// File: rtl/mux_scan_pkg.sv
// rtl/mux_scan_pkg.sv - shared state type, defaults and width helper for the mux scan sequencer
package mux_scan_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} scan_state_t;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_DWELL  = 1;

  // Width needed to index n values; never below 1 so single-value counters stay legal.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scan_dwell_timer.sv
// rtl/scan_dwell_timer.sv - dwell counter with clear, pulses done on its last count
module scan_dwell_timer
  import mux_scan_pkg::*;
#(
  parameter int DWELL = DEF_DWELL
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic done
);

  localparam int CNT_W = sel_width(DWELL);

  logic [CNT_W-1:0] cnt;

  assign done = en && (cnt == CNT_W'(DWELL - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || clear || done) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mux_scan_sequencer.sv
// rtl/mux_scan_sequencer.sv - steps a mux select, samples each channel, emits one word per scan
// Optional word_parity output is enabled by defining SCAN_PARITY_EN.
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DWELL  = DEF_DWELL,
  parameter int SEL_W  = sel_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode_cont,
  input  logic              mux_y,
  output logic [SEL_W-1:0]  sel,
  output logic [NUM_CH-1:0] word,
  output logic              word_valid,
  input  logic              word_ready,
`ifdef SCAN_PARITY_EN
  output logic              word_parity,
`endif
  output logic              busy
);

  scan_state_t       state;
  logic [NUM_CH-1:0] shadow;
  logic [NUM_CH-1:0] sample_bits;
  logic              dwell_done;
  logic              last_ch;

  scan_dwell_timer #(.DWELL(DWELL)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state != SETTLE),
    .en    (state == SETTLE),
    .done  (dwell_done)
  );

  // Shadow with the bit being sampled on this edge already merged in.
  always_comb begin
    sample_bits      = shadow;
    sample_bits[sel] = mux_y;
  end

  assign last_ch = (sel == SEL_W'(NUM_CH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel        <= '0;
      shadow     <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      busy       <= 1'b0;
`ifdef SCAN_PARITY_EN
      word_parity <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= SETTLE;
            sel    <= '0;
            shadow <= '0;
            busy   <= 1'b1;
          end
        end
        SETTLE: begin
          if (dwell_done) begin
            shadow <= sample_bits;
            if (!last_ch) begin
              sel <= sel + SEL_W'(1);
            end else begin
              word       <= sample_bits;
              word_valid <= 1'b1;
              state      <= HOLD;
`ifdef SCAN_PARITY_EN
              word_parity <= ^sample_bits;
`endif
            end
          end
        end
        HOLD: begin
          if (word_ready) begin
            word_valid <= 1'b0;
            if (mode_cont) begin
              state  <= SETTLE;
              sel    <= '0;
              shadow <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb/tb_mux_scan_sequencer.sv - self-checking bench closing the loop through a 4:1 mux model
module tb_mux_scan_sequencer;

  localparam int NCH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  // DUT with DWELL=1
  logic       start1, mode1, ready1, y1, valid1, busy1;
  logic [1:0] sel1;
  logic [3:0] word1, d1;
  // DUT with DWELL=3
  logic       start3, mode3, ready3, y3, valid3, busy3;
  logic [1:0] sel3;
  logic [3:0] word3, d3;
`ifdef SCAN_PARITY_EN
  logic       par1, par3;
`endif

  logic [3:0] hist [int];
  bit         rand_d = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  assign y1 = d1[sel1];
  assign y3 = d3[sel3];

  mux_scan_sequencer #(.NUM_CH(4), .DWELL(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start1), .mode_cont(mode1), .mux_y(y1),
    .sel(sel1), .word(word1), .word_valid(valid1), .word_ready(ready1),
`ifdef SCAN_PARITY_EN
    .word_parity(par1),
`endif
    .busy(busy1)
  );

  mux_scan_sequencer #(.NUM_CH(4), .DWELL(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .mode_cont(mode3), .mux_y(y3),
    .sel(sel3), .word(word3), .word_valid(valid3), .word_ready(ready3),
`ifdef SCAN_PARITY_EN
    .word_parity(par3),
`endif
    .busy(busy3)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Advance one edge; inputs change 1 time unit after the edge, outputs are checked there too.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_d) d1 = 4'($urandom);
    hist[cyc] = d1;
  endtask

  typedef struct {
    logic [3:0] d;
    logic [3:0] exp_word;
    logic       exp_par;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{4'b1001, 4'b1001, 1'b0};
    vecs[1] = '{4'b0110, 4'b0110, 1'b0};
    vecs[2] = '{4'b1110, 4'b1110, 1'b1};
    vecs[3] = '{4'b0000, 4'b0000, 1'b0};
    vecs[4] = '{4'b1111, 4'b1111, 1'b0};

    rst_n = 0; start1 = 0; mode1 = 0; ready1 = 0; d1 = 0;
    start3 = 0; mode3 = 0; ready3 = 1; d3 = 0;
    #1;
    tick(); tick();
    chk("rst_sel", 32'(sel1), 0);
    chk("rst_word", 32'(word1), 0);
    chk("rst_valid", 32'(valid1), 0);
    chk("rst_busy", 32'(busy1), 0);
    chk("rst_valid3", 32'(valid3), 0);
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_sel", 32'(sel1), 0);
      chk("idle_busy", 32'(busy1), 0);
    end

    // Table-driven single scans, DWELL=1, consumer always ready
    ready1 = 1;
    foreach (vecs[v]) begin
      d1 = vecs[v].d;
      start1 = 1; tick(); start1 = 0;
      chk("scan_busy", 32'(busy1), 1);
      chk("scan_sel0", 32'(sel1), 0);
      for (int i = 1; i < NCH; i++) begin
        tick();
        chk("scan_sel_step", 32'(sel1), 32'(i));
        chk("scan_no_valid", 32'(valid1), 0);
      end
      tick();
      chk("scan_valid", 32'(valid1), 1);
      chk("scan_word", 32'(word1), 32'(vecs[v].exp_word));
      chk("scan_sel_hold", 32'(sel1), 3);
`ifdef SCAN_PARITY_EN
      chk("scan_parity", 32'(par1), 32'(vecs[v].exp_par));
`endif
      tick();
      chk("scan_valid_drop", 32'(valid1), 0);
      chk("scan_idle", 32'(busy1), 0);
      chk("scan_word_kept", 32'(word1), 32'(vecs[v].exp_word));
    end

    // Backpressure: word stable while held, mux changes and start ignored
    ready1 = 0; d1 = 4'b1001;
    start1 = 1; tick(); start1 = 0;
    repeat (4) tick();
    chk("bp_valid", 32'(valid1), 1);
    d1 = 4'b0110;
    for (int i = 0; i < 10; i++) begin
      start1 = (i == 3);
      tick();
      chk("bp_word_stable", 32'(word1), 32'h9);
      chk("bp_valid_held", 32'(valid1), 1);
    end
    start1 = 0; ready1 = 1;
    tick();
    chk("bp_release", 32'(valid1), 0);
    chk("bp_idle", 32'(busy1), 0);

    // Continuous mode: each handshake restarts the scan at sel=0
    mode1 = 1; d1 = 4'b0110;
    start1 = 1; tick(); start1 = 0;
    for (int s = 0; s < 3; s++) begin
      for (int k = 1; k < NCH; k++) begin
        start1 = (k == 2);
        tick();
        chk("cont_no_valid", 32'(valid1), 0);
      end
      start1 = 0;
      tick();
      chk("cont_valid", 32'(valid1), 1);
      chk("cont_word", 32'(word1), 32'h6);
      if (s == 2) mode1 = 0;
      tick();
      chk("cont_drop", 32'(valid1), 0);
      chk("cont_busy", 32'(busy1), (s < 2) ? 1 : 0);
      if (s < 2) chk("cont_sel0", 32'(sel1), 0);
    end

    // Reset mid-scan
    d1 = 4'b1001;
    start1 = 1; tick(); start1 = 0;
    tick(); tick();
    chk("abort_sel2", 32'(sel1), 2);
    rst_n = 0;
    tick();
    chk("abort_sel", 32'(sel1), 0);
    chk("abort_word", 32'(word1), 0);
    chk("abort_busy", 32'(busy1), 0);
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("abort_no_valid", 32'(valid1), 0);
    end
    d1 = 4'b1110;
    start1 = 1; tick(); start1 = 0;
    repeat (4) tick();
    chk("after_abort_valid", 32'(valid1), 1);
    chk("after_abort_word", 32'(word1), 32'hE);
    tick();

    // DWELL=3 instance: each channel held 3 cycles, valid 12 edges after start
    for (int p = 0; p < 2; p++) begin
      d3 = (p == 0) ? 4'b0111 : 4'b0011;
      start3 = 1; tick(); start3 = 0;
      for (int t = 0; t < 12; t++) begin
        chk("d3_sel", 32'(sel3), 32'(t / 3));
        chk("d3_no_valid", 32'(valid3), 0);
        tick();
      end
      chk("d3_valid", 32'(valid3), 1);
      chk("d3_word", 32'(word3), 32'(d3));
`ifdef SCAN_PARITY_EN
      chk("d3_parity", 32'(par3), (p == 0) ? 1 : 0);
`endif
      tick();
      chk("d3_drop", 32'(valid3), 0);
    end

    // Randomized: mux data changes every cycle; expected bits come from the sampling schedule
    begin
      int b_edge;
      int dly;
      logic [3:0] exp_w;
      rand_d = 1; b_edge = -1; mode1 = 0; ready1 = 0;
      for (int s = 0; s < 40; s++) begin
        if (b_edge < 0) begin
          start1 = 1; tick(); start1 = 0;
          b_edge = cyc;
        end
        for (int k = 1; k < NCH; k++) begin
          start1 = 1'($urandom); ready1 = 1'($urandom);
          tick();
          chk("rnd_no_valid", 32'(valid1), 0);
        end
        start1 = 0; ready1 = 1'($urandom);
        tick();
        for (int i = 0; i < NCH; i++) exp_w[i] = hist[b_edge + i][i];
        chk("rnd_latency", 32'(valid1), 1);
        chk("rnd_word", 32'(word1), 32'(exp_w));
`ifdef SCAN_PARITY_EN
        chk("rnd_parity", 32'(par1), 32'(^exp_w));
`endif
        dly = $urandom_range(0, 3);
        ready1 = 0;
        for (int i = 0; i < dly; i++) begin
          start1 = 1'($urandom);
          tick();
          chk("rnd_hold_word", 32'(word1), 32'(exp_w));
          chk("rnd_hold_valid", 32'(valid1), 1);
        end
        start1 = 0; mode1 = 1'($urandom); ready1 = 1;
        tick();
        ready1 = 0;
        chk("rnd_drop", 32'(valid1), 0);
        chk("rnd_busy", 32'(busy1), 32'(mode1));
        b_edge = mode1 ? cyc : -1;
      end
      rand_d = 0; mode1 = 0;
      if (b_edge >= 0) begin
        repeat (NCH) tick();
        ready1 = 1; tick(); ready1 = 0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
